// File: rtl/des_pkg.sv
// Shared types and constants for the DES command sequencer.
// State encodings, CTRL word layout and the reserved-bit check.
package des_pkg;

    localparam int DES_WORD_W       = 64;
    localparam int CTRL_DECRYPT_BIT = 0;
    localparam int CTRL_RSVD_MSB    = 63;

    localparam logic [2:0] ST_W_KEY  = 3'd0;
    localparam logic [2:0] ST_W_DATA = 3'd1;
    localparam logic [2:0] ST_W_CTRL = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        W_KEY  = ST_W_KEY,
        W_DATA = ST_W_DATA,
        W_CTRL = ST_W_CTRL,
        START  = ST_START,
        RUN    = ST_RUN,
        DONE   = ST_DONE
    } seq_state_t;

    // Any set bit above the mode bit makes the CTRL word illegal.
    function automatic logic ctrl_bad(input logic [DES_WORD_W-1:0] w);
        return |w[CTRL_RSVD_MSB:CTRL_DECRYPT_BIT+1];
    endfunction

endpackage

// File: rtl/des_seq_timer.sv
// Watchdog for the DES core run phase.
// expire flags the enabled cycle whose increment reaches TIMEOUT_CYCLES-1.
module des_seq_timer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] SAT  = '1;

    logic [CNT_W-1:0] cnt;

    // Saturating counter: cleared on launch, counts while the core runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && (cnt >= LAST);

endmodule

// File: rtl/des_cmd_sequencer.sv
// Sequences KEY/DATA/CTRL frames from the SPI slave into one DES run,
// watchdogs the core and holds the result for SPI readout.
module des_cmd_sequencer
    import des_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [63:0] rx_data,
    output logic        core_start,
    output logic        core_decrypt,
    output logic [63:0] core_key,
    output logic [63:0] core_data,
    input  logic        core_done,
    input  logic [63:0] core_result,
    output logic [63:0] tx_data,
    output logic        busy,
    output logic        done_encrypt,
    output logic        done_decrypt,
    output logic        err_timeout,
    output logic        err_cmd
);

    seq_state_t state;
    logic       expire;

    des_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == START),
        .enable(state == RUN),
        .expire(expire)
    );

    // Command FSM with registered outputs, operands and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= W_KEY;
            core_start   <= 1'b0;
            core_decrypt <= 1'b0;
            core_key     <= '0;
            core_data    <= '0;
            tx_data      <= '0;
            busy         <= 1'b0;
            done_encrypt <= 1'b0;
            done_decrypt <= 1'b0;
            err_timeout  <= 1'b0;
            err_cmd      <= 1'b0;
        end else begin
            core_start <= 1'b0;
            unique case (state)
                W_KEY: begin
                    if (rx_valid) begin
                        core_key    <= rx_data;
                        err_timeout <= 1'b0;
                        err_cmd     <= 1'b0;
                        state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (rx_valid) begin
                        core_data <= rx_data;
                        state     <= W_CTRL;
                    end
                end
                W_CTRL: begin
                    if (rx_valid) begin
                        if (ctrl_bad(rx_data)) begin
                            err_cmd <= 1'b1;
                            state   <= W_KEY;
                        end else begin
                            core_decrypt <= rx_data[CTRL_DECRYPT_BIT];
                            core_start   <= 1'b1;
                            busy         <= 1'b1;
                            state        <= START;
                        end
                    end
                end
                START: begin
                    if (rx_valid) err_cmd <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    if (rx_valid) err_cmd <= 1'b1;
                    if (core_done) begin
                        tx_data      <= core_result;
                        done_decrypt <= core_decrypt;
                        done_encrypt <= !core_decrypt;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else if (expire) begin
                        tx_data     <= '0;
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (rx_valid) begin
                        done_encrypt <= 1'b0;
                        done_decrypt <= 1'b0;
                        state        <= W_KEY;
                    end
                end
                default: begin
                    state <= W_KEY;
                end
            endcase
        end
    end

endmodule
